window_scheduler: RTL and testbench
===================================

WINDOW_SCHEDULER -- requirements
Module: window_scheduler

Interface
REQ-001 Parameter WORD_SIZE, default 8: pixel width in bits.
REQ-002 Parameter BUFFER_SIZE, default 3: window edge K of the controlled sliding window.
REQ-003 Parameter ROW_SIZE, default 540: pixels per image row.
REQ-004 Parameter COL_SIZE, default 540: rows per frame.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  single-cycle frame start request.
REQ-008 in_valid  input  1  upstream pixel valid.
REQ-009 in_ready  output  1  scheduler accepts pixel this cycle.
REQ-010 in_pixel  input  WORD_SIZE  upstream pixel.
REQ-011 win_en  output  1  shift enable to the sliding window datapath.
REQ-012 win_pixel  output  WORD_SIZE  pixel forwarded to the window, equals in_pixel combinationally.
REQ-013 out_valid  output  1  window at current position is complete and valid.
REQ-014 out_ready  input  1  downstream convolution engine consumes the window.
REQ-015 out_row, out_col  output  $clog2(COL_SIZE), $clog2(ROW_SIZE)  top-left output coordinate of the valid window.
REQ-016 busy  output  1  frame in progress.
REQ-017 frame_done  output  1  one-cycle pulse at frame end.
REQ-018 err  output  1  sticky protocol error flag (see Configuration).

Function
REQ-019 FSM states IDLE, ACTIVE, FLUSH; IDLE->ACTIVE on start; ACTIVE->FLUSH on acceptance of pixel (COL_SIZE-1, ROW_SIZE-1); FLUSH->IDLE when out_valid is 0 or out_valid&&out_ready.
REQ-020 start outside IDLE is ignored.
REQ-021 in_ready = (state==ACTIVE) && (!out_valid || out_ready); in_ready never depends on in_valid.
REQ-022 Pixel accepted iff in_valid && in_ready; win_en equals acceptance exactly, same cycle.
REQ-023 Column counter c increments per accepted pixel, wraps to 0 after ROW_SIZE-1 and increments row counter r; both clear on IDLE->ACTIVE.
REQ-024 Accepting pixel at (r,c) with r>=K-1 and c>=K-1 sets out_valid next cycle, out_row=r-(K-1), out_col=c-(K-1); latency exactly 1 cycle.
REQ-025 out_valid, out_row, out_col hold stable while out_valid && !out_ready.
REQ-026 out_valid clears the cycle after out_valid && out_ready unless a new qualifying pixel is accepted that same cycle, in which case it stays 1 with new coordinates.
REQ-027 Pixels with r<K-1 or c<K-1 (fill and row-wrap positions) produce no out_valid.
REQ-028 Windows per frame exactly (ROW_SIZE-K+1)*(COL_SIZE-K+1).
REQ-029 frame_done pulses for one cycle on FLUSH->IDLE; busy = (state!=IDLE).

Reset
REQ-030 rst low asynchronously forces state IDLE, r=0, c=0, out_valid=0, out_row=0, out_col=0, frame_done=0, err=0; in_ready and win_en read 0.
REQ-031 Reset mid-frame discards the partial frame; no frame_done is produced.

Configuration
REQ-032 Macro WINDOW_SCHEDULER_ERR_EN defined: err sets and holds until reset when start arrives outside IDLE or in_valid is 1 while state is IDLE.
REQ-033 Macro undefined: err tied to 0, no error logic; all other behaviour identical.

Verification (ROW_SIZE=5, COL_SIZE=4, K=3 unless stated)
REQ-034 start, 20 pixels back-to-back, out_ready=1 -> 6 out_valid cycles, coordinates (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); frame_done 2 cycles after the last pixel is accepted (FLUSH->IDLE).
REQ-035 out_ready=0 held 4 cycles after first out_valid -> in_ready=0, win_en=0, out_row/out_col stable at (0,0) throughout.
REQ-036 Pixels 0-11 only -> out_valid first asserts the cycle after pixel 12 (r=2,c=2) is accepted; none earlier.
REQ-037 rst low at pixel 8, then release and new start -> counters restart at (0,0), no frame_done for aborted frame, next frame gives 6 windows.
REQ-038 WINDOW_SCHEDULER_ERR_EN defined, start pulsed while busy -> err=1 and stays 1, frame unaffected; macro undefined -> err=0.

Source files
------------

// File: rtl/window_scheduler_if.sv
// rtl/window_scheduler_if.sv - pixel ingress and window egress handshake bundle for window_scheduler
interface window_scheduler_if #(
    parameter int WORD_SIZE = 8,
    parameter int ROW_SIZE  = 540,
    parameter int COL_SIZE  = 540
);
    logic                        in_valid;
    logic                        in_ready;
    logic [WORD_SIZE-1:0]        in_pixel;
    logic                        win_en;
    logic [WORD_SIZE-1:0]        win_pixel;
    logic                        out_valid;
    logic                        out_ready;
    logic [$clog2(COL_SIZE)-1:0] out_row;
    logic [$clog2(ROW_SIZE)-1:0] out_col;

    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, win_en, win_pixel, out_valid, out_row, out_col
    );

    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, win_en, win_pixel, out_valid, out_row, out_col
    );
endinterface

// File: rtl/window_scheduler.sv
// rtl/window_scheduler.sv - sliding-window scan scheduler; optional WINDOW_SCHEDULER_ERR_EN adds sticky err
module window_scheduler #(
    parameter int WORD_SIZE   = 8,
    parameter int BUFFER_SIZE = 3,
    parameter int ROW_SIZE    = 540,
    parameter int COL_SIZE    = 540
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    window_scheduler_if.slave   bus,
    output logic                busy,
    output logic                frame_done,
    output logic                err
);
    localparam int RW = $clog2(COL_SIZE);
    localparam int CW = $clog2(ROW_SIZE);
    localparam logic [RW-1:0] R_LAST  = RW'(COL_SIZE - 1);
    localparam logic [CW-1:0] C_LAST  = CW'(ROW_SIZE - 1);
    localparam logic [RW-1:0] R_FIRST = RW'(BUFFER_SIZE - 1);
    localparam logic [CW-1:0] C_FIRST = CW'(BUFFER_SIZE - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

    state_t        state, state_next;
    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic          ready;
    logic          accept;
    logic          last_pixel;
    logic          qualify;
    logic          leave_flush;
    logic          out_valid_q;
    logic [RW-1:0] out_row_q;
    logic [CW-1:0] out_col_q;

    // A held window blocks ingress; consuming it frees the slot in the same cycle.
    assign ready       = (state == ACTIVE) && (!out_valid_q || bus.out_ready);
    assign accept      = bus.in_valid && ready;
    assign last_pixel  = (r == R_LAST) && (c == C_LAST);
    assign qualify     = (r >= R_FIRST) && (c >= C_FIRST);
    assign leave_flush = (state == FLUSH) && (!out_valid_q || bus.out_ready);

    assign bus.in_ready  = ready;
    assign bus.win_en    = accept;
    assign bus.win_pixel = bus.in_pixel;
    assign bus.out_valid = out_valid_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_col   = out_col_q;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACTIVE;
            ACTIVE:  if (accept && last_pixel) state_next = FLUSH;
            FLUSH:   if (leave_flush) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r <= '0;
            c <= '0;
        end else if (state == IDLE && start) begin
            r <= '0;
            c <= '0;
        end else if (accept) begin
            if (c == C_LAST) begin
                c <= '0;
                r <= r + 1'b1;
            end else begin
                c <= c + 1'b1;
            end
        end
    end

    // Window origin trails the newest pixel by K-1 in both axes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else if (accept && qualify) begin
            out_valid_q <= 1'b1;
            out_row_q   <= r - R_FIRST;
            out_col_q   <= c - C_FIRST;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) frame_done <= 1'b0;
        else      frame_done <= leave_flush;
    end

`ifdef WINDOW_SCHEDULER_ERR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err <= 1'b0;
        else if ((start && state != IDLE) || (bus.in_valid && state == IDLE))
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_window_scheduler.sv
// tb/tb_window_scheduler.sv - randomized scoreboard bench for window_scheduler (5x4 frame, K=3)
module tb_window_scheduler;
    localparam int WS   = 8;
    localparam int K    = 3;
    localparam int ROW  = 5;
    localparam int COL  = 4;
    localparam int NPIX = ROW * COL;
    localparam int NWIN = (ROW - K + 1) * (COL - K + 1);

    typedef struct {int r; int c;} coord_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic busy, frame_done, err;

    window_scheduler_if #(.WORD_SIZE(WS), .ROW_SIZE(ROW), .COL_SIZE(COL)) bus ();

    window_scheduler #(
        .WORD_SIZE(WS), .BUFFER_SIZE(K), .ROW_SIZE(ROW), .COL_SIZE(COL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .busy(busy), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    coord_t exp_q[$];
    int     passed = 0;
    int     total  = 0;

    // Reference model state describing the cycle that follows each falling edge.
    bit m_busy = 0, m_active = 0, m_done = 0, m_err = 0;
    int m_pix = 0;
    bit mv_acc, mv_busy, mv_active, mv_done;
    int mv_r, mv_c;

    always @(negedge clk) begin
        if (!rst) begin
            m_busy = 0; m_active = 0; m_done = 0; m_err = 0; m_pix = 0;
            exp_q.delete();
        end else begin
            mv_acc    = bus.in_valid && bus.in_ready;
            mv_busy   = m_busy;
            mv_active = m_active;
            mv_done   = 0;
`ifdef WINDOW_SCHEDULER_ERR_EN
            if ((start && m_busy) || (bus.in_valid && !m_busy)) m_err = 1;
`endif
            if (!m_busy && start) begin
                mv_busy = 1; mv_active = 1; m_pix = 0;
            end
            if (m_active && mv_acc) begin
                mv_r = m_pix / ROW;
                mv_c = m_pix % ROW;
                if (mv_r >= K - 1 && mv_c >= K - 1)
                    exp_q.push_back('{r: mv_r - (K - 1), c: mv_c - (K - 1)});
                m_pix++;
                if (m_pix == NPIX) mv_active = 0;
            end
            if (m_busy && !m_active && (!bus.out_valid || bus.out_ready)) begin
                mv_busy = 0; mv_done = 1;
            end
            m_busy = mv_busy; m_active = mv_active; m_done = mv_done;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    int pops = 0;
    coord_t front;

    always @(posedge clk) begin
        #2;
        if (!rst) begin
            chk("rst_busy", busy, 0);
            chk("rst_in_ready", bus.in_ready, 0);
            chk("rst_win_en", bus.win_en, 0);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_row", bus.out_row, 0);
            chk("rst_out_col", bus.out_col, 0);
            chk("rst_frame_done", frame_done, 0);
            chk("rst_err", err, 0);
            pops = 0;
        end else begin
            chk("busy", busy, m_busy);
            chk("frame_done", frame_done, m_done);
            chk("err", err, m_err);
            chk("in_ready", bus.in_ready, m_active && (!bus.out_valid || bus.out_ready));
            chk("win_en", bus.win_en, bus.in_valid && m_active && (!bus.out_valid || bus.out_ready));
            chk("win_pixel", bus.win_pixel, bus.in_pixel);
            if (exp_q.size() > 0) begin
                front = exp_q[0];
                chk("out_valid", bus.out_valid, 1);
                chk("out_row", bus.out_row, front.r);
                chk("out_col", bus.out_col, front.c);
                if (bus.out_valid && bus.out_ready) begin
                    void'(exp_q.pop_front());
                    pops++;
                end
            end else begin
                chk("no_spurious_valid", bus.out_valid, 0);
            end
            if (frame_done) begin
                chk("windows_per_frame", pops, NWIN);
                pops = 0;
            end
        end
    end

    task automatic run_frame(input int vp, input int rp, input int stall,
                             input int abort_at, input bit dup_start);
        int acc = 0;
        int cycles = 0;
        int stall_left = stall;
        bit dup_done = 0;
        @(posedge clk); #1;
        start = 1'b1; bus.in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        forever begin
            bus.in_valid = busy && ($urandom_range(99) < vp);
            bus.in_pixel = WS'($urandom);
            if (stall_left > 0 && bus.out_valid) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else begin
                bus.out_ready = ($urandom_range(99) < rp);
            end
            start = (dup_start && !dup_done && acc == 10);
            if (start) dup_done = 1;
            @(negedge clk);
            if (bus.win_en) acc++;
            if (frame_done) break;
            if (abort_at >= 0 && acc == abort_at) begin
                @(posedge clk); #1;
                rst = 1'b0; bus.in_valid = 1'b0; start = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst = 1'b1;
                return;
            end
            cycles++;
            if (cycles > 2000) begin
                $display("FAIL frame_timeout: got no frame_done after %0d cycles expected done", cycles);
                $fatal(1, "frame did not complete");
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_pixel  = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        run_frame(100, 100, 0, -1, 0);
        run_frame(100, 100, 4, -1, 0);
        run_frame(100, 100, 0, 8, 0);
        run_frame(100, 100, 0, -1, 0);
        run_frame(70, 70, 0, -1, 1);
        for (int i = 0; i < 4; i++) run_frame(60, 60, $urandom_range(3), -1, 0);
        repeat (4) @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
